ntsc_clock_scheduler: RTL

NTSC_CLOCK_SCHEDULER -- requirements
Module: ntsc_clock_scheduler

---
 rtl/ntsc_clock_scheduler.sv | 113 +++++++++++
 1 files changed

// File: rtl/ntsc_clock_scheduler.sv
// Clock-enable scheduler for an NTSC 8x colorburst clock: qualifies PLL lock, sequences the
// downstream reset, then generates 1/8 (VDP) and 1/64 (sound) enables from a free-running phase.
module ntsc_clock_scheduler #(
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned RESET_HOLD_CYCLES  = 16
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       vdp_hold,
    input  logic       lock_lost_clr,
    output logic       sys_reset_out,
    output logic       vdp_ce,
    output logic       snd_ce,
    output logic [5:0] phase,
    output logic [1:0] state,
    output logic       lock_lost
);

    typedef enum logic [1:0] {
        StWaitLock  = 2'd0,
        StStabilize = 2'd1,
        StResetHold = 2'd2,
        StRun       = 2'd3
    } state_e;

    // Counters are sized for the parameter maxima so they can never wrap inside a state.
    localparam logic [15:0] StableLast = 16'(LOCK_STABLE_CYCLES - 1);
    localparam logic [7:0]  HoldLast   = 8'(RESET_HOLD_CYCLES - 1);

    state_e      state_q;
    logic        sync1_q;
    logic        lock_s_q;
    logic [15:0] stab_cnt_q;
    logic [7:0]  hold_cnt_q;
    logic [5:0]  phase_q;
    logic        lock_lost_q;

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q     <= StWaitLock;
            sync1_q     <= 1'b0;
            lock_s_q    <= 1'b0;
            stab_cnt_q  <= '0;
            hold_cnt_q  <= '0;
            phase_q     <= '0;
            lock_lost_q <= 1'b0;
        end else begin
            sync1_q  <= pll_locked;
            lock_s_q <= sync1_q;

            // A set from the RUN branch below is assigned later and therefore wins.
            if (lock_lost_clr) begin
                lock_lost_q <= 1'b0;
            end

            case (state_q)
                StWaitLock: begin
                    stab_cnt_q <= '0;
                    hold_cnt_q <= '0;
                    phase_q    <= '0;
                    if (lock_s_q) begin
                        state_q <= StStabilize;
                    end
                end
                StStabilize: begin
                    if (!lock_s_q) begin
                        state_q    <= StWaitLock;
                        stab_cnt_q <= '0;
                    end else if (stab_cnt_q == StableLast) begin
                        state_q    <= StResetHold;
                        stab_cnt_q <= '0;
                    end else begin
                        stab_cnt_q <= stab_cnt_q + 16'd1;
                    end
                end
                StResetHold: begin
                    if (!lock_s_q) begin
                        state_q    <= StWaitLock;
                        hold_cnt_q <= '0;
                    end else if (hold_cnt_q == HoldLast) begin
                        state_q    <= StRun;
                        hold_cnt_q <= '0;
                        phase_q    <= '0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 8'd1;
                    end
                end
                StRun: begin
                    if (!lock_s_q) begin
                        state_q     <= StWaitLock;
                        phase_q     <= '0;
                        lock_lost_q <= 1'b1;
                    end else begin
                        phase_q <= phase_q + 6'd1;
                    end
                end
                default: begin
                    state_q <= StWaitLock;
                end
            endcase
        end
    end

    // Enables are decoded straight from registered state so they can never appear outside RUN.
    assign state         = state_q;
    assign sys_reset_out = (state_q != StRun);
    assign phase         = phase_q;
    assign vdp_ce        = (state_q == StRun) && (phase_q[2:0] == 3'd7) && !vdp_hold;
    assign snd_ce        = (state_q == StRun) && (phase_q == 6'd63);
    assign lock_lost     = lock_lost_q;

endmodule
